tick_sequencer: RTL



---
 rtl/tick_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/tick_sequencer.sv
// Programmable tick strobe generator with free-run and fixed-length burst modes.
// Optional single-step ticking from IDLE is enabled by defining TICK_SEQUENCER_SINGLE_STEP_EN.
module tick_sequencer #(
    parameter int unsigned DivWidth   = 16,
    parameter int unsigned BurstWidth = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Stop,
    input  logic                  Mode,
    input  logic [DivWidth-1:0]   Divisor,
    input  logic [BurstWidth-1:0] BurstLen,
`ifdef TICK_SEQUENCER_SINGLE_STEP_EN
    input  logic                  Step,
`endif
    output logic                  Tick,
    output logic                  Busy,
    output logic                  Done,
    output logic [BurstWidth-1:0] TickCount
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [DivWidth-1:0]   DivOne   = DivWidth'(1);
    localparam logic [BurstWidth-1:0] CountOne = BurstWidth'(1);

    state_t                 state_q, state_d;
    logic [DivWidth-1:0]    cnt_q, cnt_d;
    logic [DivWidth-1:0]    div_q, div_d;
    logic [BurstWidth-1:0]  len_q, len_d;
    logic                   mode_q, mode_d;
    logic [BurstWidth-1:0]  count_q, count_d;
    logic                   tick_q, tick_d;
    logic [DivWidth-1:0]    div_eff;
    logic                   step_req;
    logic                   burst_end;

`ifdef TICK_SEQUENCER_SINGLE_STEP_EN
    assign step_req = Step;
`else
    assign step_req = 1'b0;
`endif

    assign div_eff   = (Divisor == '0) ? DivOne : Divisor;
    assign burst_end = mode_q && (count_q == len_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        len_d   = len_q;
        mode_d  = mode_q;
        count_d = count_q;
        tick_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (Start && !Stop) begin
                    state_d = S_RUN;
                    div_d   = div_eff;
                    cnt_d   = div_eff - DivOne;
                    len_d   = BurstLen;
                    mode_d  = Mode;
                    count_d = '0;
                end else if (step_req && !Start) begin
                    tick_d  = 1'b1;
                    count_d = count_q + CountOne;
                end
            end
            S_RUN: begin
                // Completion and Stop take precedence over a tick due on the same edge.
                if (Stop || burst_end) begin
                    state_d = S_DONE;
                end else if (cnt_q == '0) begin
                    tick_d  = 1'b1;
                    count_d = count_q + CountOne;
                    cnt_d   = div_q - DivOne;
                end else begin
                    cnt_d = cnt_q - DivOne;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            len_q   <= '0;
            mode_q  <= 1'b0;
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign Tick      = tick_q;
    assign Busy      = (state_q == S_RUN);
    assign Done      = (state_q == S_DONE);
    assign TickCount = count_q;

endmodule
